seq_inst_issue: RTL and testbench
=================================

Name: seq_inst_issue

Overview:
- Receive-side front end of the sequencer: converts the byte stream from the UART receiver into paced instruction strobes for the sequencer core.
- Buffers received instruction bytes in a small FIFO and issues one instruction at a time.
- Leaves gap cycles after ALU-class instructions so the core's registered ALU write-back completes before the next register-file read.
- Issues a send only when the UART transmitter is idle, then holds off so the transmitter's busy flag can rise.

Parameters:
- FIFO_DEPTH, 16, instruction-byte buffer depth; power of two, minimum 2.
- ISSUE_GAP, 1, idle cycles after a push/add/mult issue; 0 allowed.
- TX_HOLD, 2, idle cycles after a send issue; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received byte; one instruction, seq_in_width = 8.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- i_tx_busy  in  1  UART transmitter busy.
- o_inst  out  seq_in_width  instruction to the sequencer core.
- o_inst_valid  out  1  one-cycle instruction strobe.
- o_inst_send  out  1  one-cycle send strobe; asserted only with a send opcode.
- o_fifo_cnt  out  log2(FIFO_DEPTH)+1  current buffer occupancy.
- o_overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset: rst low asynchronously clears all state.
  - Outputs: o_inst=0, o_inst_valid=0, o_inst_send=0, o_fifo_cnt=0, o_overflow=0.
  - FIFO pointers and gap counter = 0; FSM = S_IDLE; buffered contents are discarded.
- FIFO:
  - Write on i_rx_valid when cnt < FIFO_DEPTH at the start of the cycle.
  - A pop in the same cycle does not free space for that write.
  - Write while full: byte dropped, o_overflow set on the next edge, held until reset.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous write and pop when not full: cnt unchanged.
  - Read is from the head; the head byte is visible combinationally to the FSM.
- Opcode: head[seq_in_width-1 -: seq_op_width] compared against seq_op_send.
  - Any other opcode, including unused codes, is ALU-class and is still issued.
- FSM states: S_IDLE, S_GAP.
  - S_IDLE, cnt==0: no action.
  - S_IDLE, head is ALU-class: pop.
    - Next edge: o_inst<=head, o_inst_valid<=1, o_inst_send<=0.
    - If ISSUE_GAP>0: gap counter<=ISSUE_GAP-1, go S_GAP. Otherwise stay in S_IDLE (back-to-back issue allowed).
  - S_IDLE, head is send, i_tx_busy==0: pop.
    - Next edge: o_inst<=head, o_inst_valid<=1, o_inst_send<=1.
    - Gap counter<=TX_HOLD-1, go S_GAP.
  - S_IDLE, head is send, i_tx_busy==1: stall; head stays; the FIFO still accepts writes.
  - S_GAP: o_inst_valid=0, o_inst_send=0. Decrement the gap counter; at 0 go S_IDLE.
- Outputs:
  - All registered.
  - Strobes last exactly one cycle.
  - o_inst holds its last issued value between strobes.
- Latency: a byte written at edge t into an empty FIFO in S_IDLE appears with o_inst_valid at edge t+2 (one cycle FIFO write, one cycle issue).
- Throughput:
  - ALU-class: one instruction per ISSUE_GAP+1 cycles.
  - Send: at most one per TX_HOLD+1 cycles, plus time spent waiting on busy.
- Busy sampling: i_tx_busy is sampled one cycle before the strobe. This is safe because only this block starts transmissions and TX_HOLD covers busy rise latency.
- Reset mid-issue: any strobe in flight is cancelled; no partial instruction survives.

Decomposition:
- Shared constants come from seq_definitions.v: seq_in_width, seq_op_width, seq_op_push/add/mult/send. Add a new constant seq_fifo_depth_default there.
- Natural sub-module: seq_inst_fifo, a synchronous byte FIFO with full/empty/count and drop-on-full. The issue FSM stays in the top level.

Test Plan:
- Reset mid-run: rst low while cnt=5 and in S_GAP -> all outputs 0 immediately, asynchronously. After release, cnt=0 and no strobe ever appears for the discarded bytes.
- Push then add, ISSUE_GAP=1: bytes arrive at edges 0,1 -> o_inst_valid pulses at edges 2 and 4 with matching o_inst; o_inst_send=0 throughout.
- Send with i_tx_busy=1 for 10 cycles, then 0 -> no strobe while busy. o_inst_valid=o_inst_send=1 for exactly one cycle, one edge after busy falls. The next instruction issues no earlier than TX_HOLD+1 cycles later.
- Overflow, FIFO_DEPTH=16, core stalled on send with busy=1: write 18 bytes -> o_fifo_cnt saturates at 16 and o_overflow=1. After busy falls, exactly 16 instructions issue, in order.
- Simultaneous write and pop at cnt=1: cnt stays 1, order is preserved, and wrap-around is exercised by streaming 40 bytes.
- ISSUE_GAP=0 with 4 ALU bytes preloaded -> four consecutive o_inst_valid cycles carrying the bytes in FIFO order.

Source files
------------

// File: rtl/seq_inst_issue_pkg.sv
// Shared sequencer constants and issue-FSM types used by the receive-side
// instruction front end.
package seq_inst_issue_pkg;

   localparam int seq_in_width           = 8;
   localparam int seq_op_width           = 3;
   localparam int seq_fifo_depth_default = 16;

   localparam logic [seq_op_width-1:0] seq_op_push = 3'd1;
   localparam logic [seq_op_width-1:0] seq_op_add  = 3'd2;
   localparam logic [seq_op_width-1:0] seq_op_mult = 3'd3;
   localparam logic [seq_op_width-1:0] seq_op_send = 3'd4;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_GAP  = 1'b1
   } issue_state_t;

   // The gap counter only ever holds reload values up to max(a, b) - 1.
   function automatic int gap_cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/seq_inst_fifo.sv
// Synchronous instruction-byte FIFO with occupancy count and sticky drop-on-full flag.
// The head entry is presented combinationally so the issue FSM can decode it.
module seq_inst_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] cnt,
   output logic                   empty,
   output logic                   overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   // Full is judged on the start-of-cycle count, so a same-cycle pop never makes room.
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (wr_en && full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/seq_inst_issue.sv
// Receive-side front end: buffers UART instruction bytes and issues them one at a
// time, pacing ALU-class ops for write-back and send ops for transmitter busy rise.
module seq_inst_issue
   import seq_inst_issue_pkg::*;
#(
   parameter int FIFO_DEPTH = seq_fifo_depth_default,
   parameter int ISSUE_GAP  = 1,
   parameter int TX_HOLD    = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [seq_in_width-1:0]      i_rx_data,
   input  logic                         i_rx_valid,
   input  logic                         i_tx_busy,
   output logic [seq_in_width-1:0]      o_inst,
   output logic                         o_inst_valid,
   output logic                         o_inst_send,
   output logic [$clog2(FIFO_DEPTH):0]  o_fifo_cnt,
   output logic                         o_overflow
);

   localparam int GAP_W = gap_cnt_width(ISSUE_GAP, TX_HOLD);
   localparam logic [GAP_W-1:0] ALU_RELOAD  = (ISSUE_GAP > 0) ? GAP_W'(ISSUE_GAP - 1) : '0;
   localparam logic [GAP_W-1:0] SEND_RELOAD = GAP_W'(TX_HOLD - 1);

   issue_state_t            state;
   issue_state_t            state_nxt;
   logic [GAP_W-1:0]        gap_cnt;
   logic [GAP_W-1:0]        gap_cnt_nxt;
   logic [seq_in_width-1:0] head;
   logic                    empty;
   logic                    pop;
   logic                    head_is_send;
   logic [seq_in_width-1:0] inst_nxt;
   logic                    valid_nxt;
   logic                    send_nxt;

   seq_inst_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (seq_in_width)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (i_rx_valid),
      .wr_data  (i_rx_data),
      .rd_en    (pop),
      .rd_data  (head),
      .cnt      (o_fifo_cnt),
      .empty    (empty),
      .overflow (o_overflow)
   );

   // Unused opcodes fall through as ALU-class and are still issued.
   assign head_is_send = (head[seq_in_width-1 -: seq_op_width] == seq_op_send);

   always_comb begin
      state_nxt   = state;
      gap_cnt_nxt = gap_cnt;
      pop         = 1'b0;
      inst_nxt    = o_inst;
      valid_nxt   = 1'b0;
      send_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty && (!head_is_send || !i_tx_busy)) begin
               pop       = 1'b1;
               inst_nxt  = head;
               valid_nxt = 1'b1;
               send_nxt  = head_is_send;
               if (head_is_send) begin
                  gap_cnt_nxt = SEND_RELOAD;
                  state_nxt   = S_GAP;
               end else if (ISSUE_GAP > 0) begin
                  gap_cnt_nxt = ALU_RELOAD;
                  state_nxt   = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt == '0) state_nxt = S_IDLE;
            else               gap_cnt_nxt = gap_cnt - 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         gap_cnt      <= '0;
         o_inst       <= '0;
         o_inst_valid <= 1'b0;
         o_inst_send  <= 1'b0;
      end else begin
         state        <= state_nxt;
         gap_cnt      <= gap_cnt_nxt;
         o_inst       <= inst_nxt;
         o_inst_valid <= valid_nxt;
         o_inst_send  <= send_nxt;
      end
   end

endmodule

// File: tb/tb_seq_inst_issue.sv
// Self-checking bench for seq_inst_issue: randomized byte streams checked against a
// queue-based issue model, plus directed pacing, stall, overflow and reset scenarios.
module tb_seq_inst_issue;
   import seq_inst_issue_pkg::*;

   localparam int DEPTH = 16;
   localparam int GAP   = 1;
   localparam int HOLD  = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          tx_busy = 1'b0;
   logic [7:0]    inst;
   logic          inst_valid;
   logic          inst_send;
   logic [CW-1:0] fifo_cnt;
   logic          overflow;

   logic [7:0]    rx_data0 = '0;
   logic          rx_valid0 = 1'b0;
   logic          busy0 = 1'b0;
   logic [7:0]    inst0;
   logic          inst_valid0;
   logic          inst_send0;
   logic [CW-1:0] fifo_cnt0;
   logic          overflow0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_inst_issue #(.FIFO_DEPTH(DEPTH), .ISSUE_GAP(GAP), .TX_HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_tx_busy(tx_busy),
      .o_inst(inst), .o_inst_valid(inst_valid), .o_inst_send(inst_send),
      .o_fifo_cnt(fifo_cnt), .o_overflow(overflow));

   seq_inst_issue #(.FIFO_DEPTH(DEPTH), .ISSUE_GAP(0), .TX_HOLD(HOLD)) dut0 (
      .clk(clk), .rst(rst), .i_rx_data(rx_data0), .i_rx_valid(rx_valid0), .i_tx_busy(busy0),
      .o_inst(inst0), .o_inst_valid(inst_valid0), .o_inst_send(inst_send0),
      .o_fifo_cnt(fifo_cnt0), .o_overflow(overflow0));

   // Reference model for dut: a byte queue plus a count of idle cycles still owed.
   logic [7:0] mq[$];
   logic [7:0] acc_log[$];
   int         cool;
   logic       m_valid, m_send, m_ovf;
   logic [7:0] m_inst;
   logic       m_acc;

   function automatic bit is_send(input logic [7:0] b);
      return b[7:5] == seq_op_send;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete(); acc_log.delete();
         cool = 0; m_valid = 0; m_send = 0; m_ovf = 0; m_inst = '0;
      end else begin
         m_acc = rx_valid && (mq.size() < DEPTH);
         if (rx_valid && !m_acc) m_ovf = 1'b1;
         if (cool == 0 && mq.size() > 0 && (!is_send(mq[0]) || !tx_busy)) begin
            m_send  = is_send(mq[0]);
            m_inst  = mq.pop_front();
            m_valid = 1'b1;
            cool    = m_send ? HOLD : GAP;
         end else begin
            m_valid = 1'b0;
            m_send  = 1'b0;
            if (cool > 0) cool--;
         end
         if (m_acc) begin
            mq.push_back(rx_data);
            acc_log.push_back(rx_data);
         end
      end
   end

   function automatic logic [7:0] mk_byte(input logic [2:0] op);
      logic [7:0] b;
      b = 8'($urandom);
      b[7:5] = op;
      return b;
   endfunction

   function automatic logic [2:0] alu_op();
      logic [2:0] o;
      o = 3'($urandom);
      if (o == seq_op_send) o = seq_op_mult;
      return o;
   endfunction

   task automatic do_reset();
      rst = 1'b0; rx_valid = 0; rx_valid0 = 0; tx_busy = 0; busy0 = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({inst_valid, inst_send, inst, fifo_cnt, overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got v=%b s=%b inst=%h cnt=%0d ovf=%b want all zero",
                  inst_valid, inst_send, inst, fifo_cnt, overflow);
      end
   endtask

   task automatic test_push_add();
      int edges[$];
      logic [7:0] got[$];
      logic [7:0] b0, b1;
      int sends;
      sends = 0;
      do_reset();
      b0 = mk_byte(seq_op_push);
      b1 = mk_byte(seq_op_add);
      for (int c = 1; c <= 8; c++) begin
         rx_valid = (c <= 2);
         rx_data  = (c == 1) ? b0 : b1;
         @(posedge clk); #1;
         n_checks++;
         if ({inst_valid, inst_send, inst, fifo_cnt, overflow} !== {m_valid, m_send, m_inst, CW'(mq.size()), m_ovf}) begin
            n_fail++;
            $display("FAIL push_add_model edge=%0d got v=%b s=%b i=%h c=%0d o=%b want v=%b s=%b i=%h c=%0d o=%b",
                     c, inst_valid, inst_send, inst, fifo_cnt, overflow, m_valid, m_send, m_inst, mq.size(), m_ovf);
         end
         if (inst_valid) begin edges.push_back(c); got.push_back(inst); end
         if (inst_send) sends++;
      end
      n_checks++;
      if (edges.size() != 2 || edges[0] != 2 || edges[1] != 4 || got[0] !== b0 || got[1] !== b1 || sends != 0) begin
         n_fail++;
         $display("FAIL push_add_timing got %0d strobes first_edge=%0d second_edge=%0d sends=%0d want edges 2,4 bytes %h,%h no send",
                  edges.size(), edges.size() > 0 ? edges[0] : -1, edges.size() > 1 ? edges[1] : -1, sends, b0, b1);
      end
   endtask

   task automatic test_send_busy();
      logic [7:0] sb;
      int strobes_busy, send_edge, alu_edge, n_send;
      strobes_busy = 0; send_edge = -1; alu_edge = -1; n_send = 0;
      do_reset();
      tx_busy = 1'b1;
      sb = mk_byte(seq_op_send);
      for (int c = 1; c <= 10; c++) begin
         rx_valid = (c <= 2);
         rx_data  = (c == 1) ? sb : mk_byte(alu_op());
         @(posedge clk); #1;
         if (inst_valid || inst_send) strobes_busy++;
      end
      rx_valid = 1'b0;
      n_checks++;
      if (strobes_busy != 0 || fifo_cnt !== CW'(2)) begin
         n_fail++;
         $display("FAIL send_stall got strobes=%0d cnt=%0d want strobes=0 cnt=2", strobes_busy, fifo_cnt);
      end
      tx_busy = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({inst_valid, inst_send, inst, fifo_cnt, overflow} !== {m_valid, m_send, m_inst, CW'(mq.size()), m_ovf}) begin
            n_fail++;
            $display("FAIL send_model edge=%0d got v=%b s=%b i=%h c=%0d want v=%b s=%b i=%h c=%0d",
                     c, inst_valid, inst_send, inst, fifo_cnt, m_valid, m_send, m_inst, mq.size());
         end
         if (inst_valid && inst_send) begin n_send++; send_edge = c; end
         if (inst_valid && !inst_send && alu_edge < 0) alu_edge = c;
      end
      n_checks++;
      if (n_send != 1 || send_edge != 1 || alu_edge - send_edge < HOLD + 1) begin
         n_fail++;
         $display("FAIL send_release got sends=%0d send_edge=%0d alu_edge=%0d want 1 send at edge 1 and alu >= %0d edges later",
                  n_send, send_edge, alu_edge, HOLD + 1);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] wr[$];
      logic [7:0] got[$];
      do_reset();
      tx_busy = 1'b1;
      for (int k = 0; k < 18; k++) begin
         rx_valid = 1'b1;
         rx_data  = (k == 0) ? mk_byte(seq_op_send) : mk_byte(alu_op());
         if (k < 16) wr.push_back(rx_data);
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (fifo_cnt !== CW'(16) || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_full got cnt=%0d ovf=%b want cnt=16 ovf=1", fifo_cnt, overflow);
      end
      tx_busy = 1'b0;
      for (int c = 0; c < 100 && got.size() < 20; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({inst_valid, inst_send, inst, fifo_cnt, overflow} !== {m_valid, m_send, m_inst, CW'(mq.size()), m_ovf}) begin
            n_fail++;
            $display("FAIL overflow_model cyc=%0d got v=%b s=%b i=%h c=%0d o=%b want v=%b s=%b i=%h c=%0d o=%b",
                     c, inst_valid, inst_send, inst, fifo_cnt, overflow, m_valid, m_send, m_inst, mq.size(), m_ovf);
         end
         if (inst_valid) got.push_back(inst);
      end
      n_checks++;
      if (got != wr) begin
         n_fail++;
         $display("FAIL overflow_drain got %0d instructions want the 16 accepted bytes in order", got.size());
      end
   endtask

   task automatic test_stream();
      logic [7:0] got[$];
      int sent;
      sent = 0;
      do_reset();
      for (int c = 0; c < 400 && sent < 40; c++) begin
         rx_valid = ($urandom_range(0, 2) == 0);
         rx_data  = 8'($urandom);
         tx_busy  = ($urandom_range(0, 3) == 0);
         if (rx_valid) sent++;
         @(posedge clk); #1;
         n_checks++;
         if ({inst_valid, inst_send, inst, fifo_cnt, overflow} !== {m_valid, m_send, m_inst, CW'(mq.size()), m_ovf}) begin
            n_fail++;
            $display("FAIL stream_model cyc=%0d got v=%b s=%b i=%h c=%0d o=%b want v=%b s=%b i=%h c=%0d o=%b",
                     c, inst_valid, inst_send, inst, fifo_cnt, overflow, m_valid, m_send, m_inst, mq.size(), m_ovf);
         end
         if (inst_valid) got.push_back(inst);
      end
      rx_valid = 1'b0;
      tx_busy  = 1'b0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk); #1;
         if (inst_valid) got.push_back(inst);
      end
      n_checks++;
      if (got != acc_log || sent != 40 || fifo_cnt !== '0) begin
         n_fail++;
         $display("FAIL stream_order got %0d issued cnt=%0d want %0d accepted in order cnt=0 (sent=%0d)",
                  got.size(), fifo_cnt, acc_log.size(), sent);
      end
   endtask

   task automatic test_reset_mid_run();
      bit hit;
      int late;
      hit = 0; late = 0;
      do_reset();
      for (int c = 0; c < 40 && !hit; c++) begin
         rx_valid = 1'b1;
         rx_data  = mk_byte(alu_op());
         @(posedge clk); #1;
         if (mq.size() == 5 && cool > 0) hit = 1;
      end
      n_checks++;
      if (!hit || fifo_cnt !== CW'(5)) begin
         n_fail++;
         $display("FAIL reset_setup got reached=%0d cnt=%0d want reached=1 cnt=5", hit, fifo_cnt);
      end
      rx_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({inst_valid, inst_send, inst, fifo_cnt, overflow} !== '0) begin
         n_fail++;
         $display("FAIL reset_async got v=%b s=%b i=%h c=%0d o=%b want all zero",
                  inst_valid, inst_send, inst, fifo_cnt, overflow);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (inst_valid || inst_send || fifo_cnt !== '0) late++;
      end
      n_checks++;
      if (late != 0) begin
         n_fail++;
         $display("FAIL reset_discard got %0d cycles with strobe or nonzero cnt want 0", late);
      end
   endtask

   task automatic test_gap0();
      logic [7:0] exp_b[$];
      logic [7:0] got[$];
      int edges[$];
      bit sends[$];
      bit bad;
      bad = 0;
      do_reset();
      busy0     = 1'b1;
      rx_valid0 = 1'b1;
      rx_data0  = mk_byte(seq_op_send);
      exp_b.push_back(rx_data0);
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         rx_data0 = mk_byte(alu_op());
         exp_b.push_back(rx_data0);
         @(posedge clk); #1;
      end
      rx_valid0 = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (inst_valid0 !== 1'b0 || fifo_cnt0 !== CW'(5) || overflow0 !== 1'b0) begin
         n_fail++;
         $display("FAIL gap0_preload got v=%b cnt=%0d ovf=%b want v=0 cnt=5 ovf=0", inst_valid0, fifo_cnt0, overflow0);
      end
      busy0 = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (inst_valid0) begin got.push_back(inst0); edges.push_back(c); sends.push_back(inst_send0); end
      end
      n_checks++;
      if (got.size() != 5) begin
         n_fail++;
         $display("FAIL gap0_count got %0d strobes want 5", got.size());
      end else begin
         if (got != exp_b || sends[0] != 1 || edges[0] != 1 || edges[1] != 1 + HOLD + 1) bad = 1;
         for (int i = 1; i < 5; i++) if (sends[i] != 0) bad = 1;
         for (int i = 2; i < 5; i++) if (edges[i] != edges[i-1] + 1) bad = 1;
         n_checks++;
         if (bad) begin
            n_fail++;
            $display("FAIL gap0_burst got edges %0d,%0d,%0d,%0d,%0d want 1,%0d,%0d,%0d,%0d with bytes in order",
                     edges[0], edges[1], edges[2], edges[3], edges[4], HOLD + 2, HOLD + 3, HOLD + 4, HOLD + 5);
         end
      end
   endtask

   initial begin
      test_reset();
      test_push_add();
      test_send_busy();
      test_overflow();
      test_stream();
      test_reset_mid_run();
      test_gap0();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
